// File: rtl/text_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_pkg                                                     |
// | Description : Shared geometry, character codes and state encoding for the  |
// |               15x40 character-cell text buffer.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package text_pkg;

    localparam int ROWS   = 15;
    localparam int COLS   = 40;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 6;
    localparam int CHAR_W = 8;
    localparam int IDX_W  = 10;
    localparam int CELLS  = ROWS * COLS;

    localparam logic [CHAR_W-1:0] BLANK_ID = 8'h20;
    localparam logic [CHAR_W-1:0] CH_LF    = 8'h0A;
    localparam logic [CHAR_W-1:0] CH_CR    = 8'h0D;
    localparam logic [CHAR_W-1:0] CH_BS    = 8'h08;

    // Last cell of a sweep, and first cell of the bottom row (no scroll source below it)
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(CELLS - 1);
    localparam logic [IDX_W-1:0] BOTTOM_ROW_IDX = IDX_W'(CELLS - COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCROLL = 2'd2
    } state_e;

    // Linear cell index; operands widened first so row*COLS never truncates
    function automatic logic [IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_cell_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_cell_ram                                                |
// | Description : 600 x CHAR_W character store, one synchronous write port and |
// |               two asynchronous read ports (display read, scroll source).   |
// |               Out-of-range addresses read back as BLANK_ID.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module text_cell_ram
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [CHAR_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_a_i,
    output logic [CHAR_W-1:0] rdata_a_o,
    input  logic [IDX_W-1:0]  raddr_b_i,
    output logic [CHAR_W-1:0] rdata_b_o
);

    logic [CHAR_W-1:0] mem_q [CELLS];

    // Single write port; contents are deliberately not reset (swept by CLEAR instead)
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < IDX_W'(CELLS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i < IDX_W'(CELLS)) ? mem_q[raddr_a_i] : BLANK_ID;
    assign rdata_b_o = (raddr_b_i < IDX_W'(CELLS)) ? mem_q[raddr_b_i] : BLANK_ID;

endmodule
`default_nettype wire

// File: rtl/text_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : text_buffer                                                  |
// | Description : 15x40 text screen store. Accepts a valid/ready byte stream,  |
// |               tracks the write cursor, handles LF/CR/BS, scrolls one row   |
// |               on overflow and serves a combinational character read port.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module text_buffer
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_valid,
    input  logic [CHAR_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [CHAR_W-1:0] rd_char,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic               busy_q;

    logic               accept;
    logic [IDX_W-1:0]   cur_idx;
    logic               ram_we;
    logic [IDX_W-1:0]   ram_waddr;
    logic [CHAR_W-1:0]  ram_wdata;
    logic [IDX_W-1:0]   src_addr;
    logic [CHAR_W-1:0]  src_char;
    logic [IDX_W-1:0]   rd_addr;
    logic [CHAR_W-1:0]  ram_rd_char;
    logic               rd_in_range;
    logic               at_last_row;
    logic               at_last_col;

    // busy_q mirrors (state_q != ST_IDLE); clr blocks acceptance in the same cycle
    assign wr_ready    = !busy_q && !clr;
    assign busy        = busy_q;
    assign accept      = wr_valid && wr_ready;
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;

    assign cur_idx     = cell_index(row_q, col_q);
    assign at_last_row = (row_q == ROW_W'(ROWS - 1));
    assign at_last_col = (col_q == COL_W'(COLS - 1));

    // Scroll copies each cell from the one directly below it
    assign src_addr    = idx_q + IDX_W'(COLS);

    assign rd_in_range = (rd_row < ROW_W'(ROWS)) && (rd_col < COL_W'(COLS));
    assign rd_addr     = cell_index(rd_row, rd_col);
    assign rd_char     = rd_in_range ? ram_rd_char : BLANK_ID;

    // Controller: sweep counter, cursor movement and state transitions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
        end else if (clr) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_CLEAR, ST_SCROLL: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        case (wr_data)
                            CH_LF: begin
                                col_q <= '0;
                                if (!at_last_row) begin
                                    row_q   <= row_q + 1'b1;
                                end else begin
                                    state_q <= ST_SCROLL;
                                    idx_q   <= '0;
                                    busy_q  <= 1'b1;
                                end
                            end
                            CH_CR: begin
                                col_q <= '0;
                            end
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_q <= col_q - 1'b1;
                                end else if (row_q != '0) begin
                                    row_q <= row_q - 1'b1;
                                    col_q <= COL_W'(COLS - 1);
                                end
                            end
                            default: begin
                                if (!at_last_col) begin
                                    col_q <= col_q + 1'b1;
                                end else begin
                                    col_q <= '0;
                                    if (!at_last_row) begin
                                        row_q   <= row_q + 1'b1;
                                    end else begin
                                        state_q <= ST_SCROLL;
                                        idx_q   <= '0;
                                        busy_q  <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Write-port steering: sweep writes while busy, character/backspace writes while idle
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = BLANK_ID;
        unique case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
            end
            ST_SCROLL: begin
                ram_we = 1'b1;
                if (idx_q < BOTTOM_ROW_IDX) begin
                    ram_wdata = src_char;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (wr_data)
                        CH_LF, CH_CR: begin
                            ram_we = 1'b0;
                        end
                        CH_BS: begin
                            // Cell left of the cursor, wrapping to the previous row end
                            if ((col_q != '0) || (row_q != '0)) begin
                                ram_we    = 1'b1;
                                ram_waddr = cur_idx - 1'b1;
                            end
                        end
                        default: begin
                            ram_we    = 1'b1;
                            ram_waddr = cur_idx;
                            ram_wdata = wr_data;
                        end
                    endcase
                end
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    text_cell_ram u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wdata_i   (ram_wdata),
        .raddr_a_i (rd_addr),
        .rdata_a_o (ram_rd_char),
        .raddr_b_i (src_addr),
        .rdata_b_o (src_char)
    );

endmodule
`default_nettype wire

// File: tb/tb_text_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_text_buffer                                               |
// | Description : Self-checking bench for text_buffer: vector table, directed  |
// |               scroll/clear sequences and random bytes against a 2-D model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_text_buffer;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [3:0] rd_row = 4'd0;
    logic [5:0] rd_col = 6'd0;
    logic       wr_ready;
    logic [7:0] rd_char;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model: screen as rows of characters plus a cursor
    logic [7:0] mm [0:14][0:39];
    int mr;
    int mc;

    typedef struct {
        logic [7:0] d;
        int rr;
        int rc;
        int ech;
        int erow;
        int ecol;
    } vec_t;
    vec_t tbl [12];

    text_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input int r, input int c, output int v);
        rd_row = r[3:0];
        rd_col = c[5:0];
        #1;
        v = int'(rd_char);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++)
                mm[r][c] = 8'h20;
        mr = 0;
        mc = 0;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < 14; r++)
            for (int c = 0; c < 40; c++)
                mm[r][c] = mm[r+1][c];
        for (int c = 0; c < 40; c++)
            mm[14][c] = 8'h20;
    endtask

    // Applies one accepted byte; scr reports that a scroll was started
    task automatic model_apply(input logic [7:0] b, output bit scr);
        scr = 1'b0;
        if (b == 8'h0A) begin
            mc = 0;
            if (mr < 14) mr++;
            else begin model_scroll(); scr = 1'b1; end
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h08) begin
            if (mc > 0) begin
                mc--;
                mm[mr][mc] = 8'h20;
            end else if (mr > 0) begin
                mr--;
                mc = 39;
                mm[mr][mc] = 8'h20;
            end
        end else begin
            mm[mr][mc] = b;
            if (mc < 39) mc++;
            else begin
                mc = 0;
                if (mr < 14) mr++;
                else begin model_scroll(); scr = 1'b1; end
            end
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 1000) begin
            step();
            cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit scr;
        int cyc;
        wr_data  = b;
        wr_valid = 1'b1;
        n = 0;
        #0;
        while (!wr_ready && n < 2000) begin
            step();
            n++;
        end
        if (!wr_ready) chk("send_ready_timeout", 0, 1);
        step();
        wr_valid = 1'b0;
        model_apply(b, scr);
        if (scr) begin
            chk("scroll_busy_start", int'(busy), 1);
            wait_idle(cyc);
            chk("scroll_cycles", cyc, 600);
        end
    endtask

    task automatic scan(input string tag);
        int v;
        int bad;
        int br;
        int bc;
        bad = 0;
        br = -1;
        bc = -1;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                read_cell(r, c, v);
                if (v != int'(mm[r][c])) begin
                    if (bad == 0) begin br = r; bc = c; end
                    bad++;
                end
            end
        end
        chk($sformatf("scan_%s first_bad(%0d,%0d)", tag, br, bc), bad, 0);
    endtask

    task automatic chk_cursor(input string tag);
        chk($sformatf("%s_row", tag), int'(cursor_row), mr);
        chk($sformatf("%s_col", tag), int'(cursor_col), mc);
    endtask

    initial begin
        int v;
        int cyc;
        bit scr;

        tbl[0]  = '{8'h41, 0, 0,  8'h41, 0, 1};
        tbl[1]  = '{8'h42, 0, 1,  8'h42, 0, 2};
        tbl[2]  = '{8'h0D, 0, 0,  8'h41, 0, 0};
        tbl[3]  = '{8'h43, 0, 0,  8'h43, 0, 1};
        tbl[4]  = '{8'h08, 0, 0,  8'h20, 0, 0};
        tbl[5]  = '{8'h08, 0, 0,  8'h20, 0, 0};
        tbl[6]  = '{8'h0A, 0, 1,  8'h42, 1, 0};
        tbl[7]  = '{8'h08, 0, 39, 8'h20, 0, 39};
        tbl[8]  = '{8'h5A, 0, 39, 8'h5A, 1, 0};
        tbl[9]  = '{8'h08, 0, 39, 8'h20, 0, 39};
        tbl[10] = '{8'h0A, 1, 0,  8'h20, 1, 0};
        tbl[11] = '{8'h78, 1, 0,  8'h78, 1, 1};

        // Reset and the initial clear sweep
        repeat (3) step();
        chk("reset_busy", int'(busy), 1);
        chk("reset_wr_ready", int'(wr_ready), 0);
        chk("reset_cur_row", int'(cursor_row), 0);
        chk("reset_cur_col", int'(cursor_col), 0);
        rst_n = 1'b1;
        wait_idle(cyc);
        chk("reset_clear_cycles", cyc, 600);
        chk("idle_wr_ready", int'(wr_ready), 1);
        model_clear();
        chk_cursor("post_reset");
        scan("reset");

        // Table-driven byte sequence
        for (int i = 0; i < 12; i++) begin
            send_byte(tbl[i].d);
            read_cell(tbl[i].rr, tbl[i].rc, v);
            chk($sformatf("tbl%0d_char", i), v, tbl[i].ech);
            chk($sformatf("tbl%0d_row", i), int'(cursor_row), tbl[i].erow);
            chk($sformatf("tbl%0d_col", i), int'(cursor_col), tbl[i].ecol);
        end
        scan("table");

        // Fill the screen with per-row letters, then newline on the last row scrolls
        clr = 1'b1;
        step();
        clr = 1'b0;
        wait_idle(cyc);
        chk("clr_cycles", cyc, 600);
        model_clear();
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 40; c++) begin
                if (!(r == 14 && c == 39)) send_byte(8'(8'h61 + r));
            end
        end
        chk_cursor("fill_end");
        send_byte(8'h0A);
        read_cell(0, 5, v);
        chk("scroll_row0", v, 8'h62);
        read_cell(13, 0, v);
        chk("scroll_row13", v, 8'h6F);
        read_cell(14, 0, v);
        chk("scroll_row14", v, 8'h20);
        chk("scroll_cur_row", int'(cursor_row), 14);
        chk("scroll_cur_col", int'(cursor_col), 0);
        scan("scroll");

        // Clear request in the middle of a scroll, with a byte offered at the same time
        wr_data  = 8'h0A;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        model_apply(8'h0A, scr);
        chk("lf_scroll_started", int'(busy), 1);
        repeat (300) step();
        chk("mid_scroll_busy", int'(busy), 1);
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h51;
        #1;
        chk("clr_blocks_ready_scroll", int'(wr_ready), 0);
        step();
        clr      = 1'b0;
        wr_valid = 1'b0;
        wait_idle(cyc);
        chk("clr_mid_scroll_cycles", cyc, 600);
        model_clear();
        chk_cursor("clr_mid_scroll");
        scan("clr_mid_scroll");

        // Clear in IDLE with a concurrent byte held through the busy period
        clr      = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h51;
        #1;
        chk("clr_blocks_ready_idle", int'(wr_ready), 0);
        step();
        clr = 1'b0;
        wait_idle(cyc);
        chk("held_clear_cycles", cyc, 600);
        chk("held_not_accepted_col", int'(cursor_col), 0);
        step();
        wr_valid = 1'b0;
        model_clear();
        model_apply(8'h51, scr);
        read_cell(0, 0, v);
        chk("held_accepted_char", v, 8'h51);
        chk_cursor("held_accepted");

        // Random bytes against the model
        for (int i = 0; i < 300; i++) begin
            int k;
            int rr;
            int rc;
            logic [7:0] b;
            k = int'($urandom_range(0, 99));
            if (k < 12)      b = 8'h0A;
            else if (k < 16) b = 8'h0D;
            else if (k < 30) b = 8'h08;
            else             b = 8'($urandom_range(33, 126));
            send_byte(b);
            chk_cursor($sformatf("rnd%0d", i));
            rr = int'($urandom_range(0, 14));
            rc = int'($urandom_range(0, 39));
            read_cell(rr, rc, v);
            chk($sformatf("rnd%0d_cell(%0d,%0d)", i, rr, rc), v, int'(mm[rr][rc]));
            if (i % 60 == 59) scan($sformatf("rnd%0d", i));
        end

        // Out-of-range read coordinates return blank
        read_cell(15, 0, v);
        chk("oob_row15", v, 8'h20);
        read_cell(0, 45, v);
        chk("oob_col45", v, 8'h20);
        begin
            int bad;
            bad = 0;
            for (int r = 0; r < 16; r++) begin
                for (int c = 0; c < 64; c++) begin
                    if (r >= 15 || c >= 40) begin
                        read_cell(r, c, v);
                        if (v != 8'h20) bad++;
                    end
                end
            end
            chk("oob_sweep_nonblank", bad, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
